// File: rtl/c17_bist.sv
// c17_bist: built-in self-test driver for the c17 benchmark core.
// Applies PATTERNS pseudo-random 5-bit patterns, compacts {N23,N22} into an
// 8-bit MISR and compares the final signature against GOLDEN.
//
// Optional build macro: C17_BIST_EXHAUSTIVE_EN replaces the LFSR with a 5-bit
// up-counter starting at 0 (SEED ignored).
//
// Ports:
//   CK         clock, rising edge
//   RST        synchronous active-high reset
//   start      run request, honoured in IDLE or DONE only
//   busy       high while patterns are applied
//   done       one-cycle pulse at run completion
//   pass       signature == GOLDEN, valid from done until next start/RST
//   signature  current MISR contents
//   N1..N7     registered pattern bits p[4],p[3],p[2],p[1],p[0] to the core
//   N22, N23   combinational core responses
module c17_bist #(
  parameter int unsigned PATTERNS = 31,
  parameter logic [4:0]  SEED     = 5'b00001,
  parameter logic [7:0]  GOLDEN   = 8'h00
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic       N1,
  output logic       N2,
  output logic       N3,
  output logic       N6,
  output logic       N7,
  input  logic       N22,
  input  logic       N23
);

  localparam int unsigned PW = 5;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pat_q, pat_d, pat_adv;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] misr_q, misr_d, misr_nxt;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

`ifdef C17_BIST_EXHAUSTIVE_EN
  // Counter mode: pattern tracks count[4:0], wrapping modulo 32.
  localparam logic [PW-1:0] PAT_INIT = 5'b00000;
  assign pat_adv = pat_q + PW'(1);
`else
  // Fibonacci LFSR, x^5+x^3+1.
  localparam logic [PW-1:0] PAT_INIT = SEED;
  assign pat_adv = {pat_q[3:0], pat_q[4] ^ pat_q[2]};
`endif

  // MISR, x^8+x^4+x^3+x^2+1, responses folded into the two low bits.
  assign misr_nxt = {misr_q[6:0], misr_q[7]}
                  ^ (misr_q[7] ? 8'h1C : 8'h00)
                  ^ {6'b0, N23, N22};

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    pat_d   = '0;
    cnt_d   = cnt_q;
    misr_d  = misr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          pat_d   = PAT_INIT;
          cnt_d   = '0;
          misr_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        misr_d = misr_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (misr_nxt == GOLDEN);
        end else begin
          busy_d = 1'b1;
          pat_d  = pat_adv;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; RST discards any partial run.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      misr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      misr_q  <= misr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;
  assign {N1, N2, N3, N6, N7} = pat_q;

endmodule

// File: tb/tb_c17_bist.sv
// Self-checking bench for c17_bist with a behavioural c17 core (good, n10
// stuck-at-0, tied-zero, or a random response table) and a reference model.
module tb_c17_bist;

  localparam int unsigned NP     = 31;
  localparam logic [4:0]  SEED   = 5'b00001;
  localparam logic [7:0]  GOLDEN = 8'h00;

  logic       CK = 1'b0;
  logic       RST, start;
  logic       busy, done, pass;
  logic [7:0] signature;
  logic       N1, N2, N3, N6, N7;
  logic       N22, N23;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  logic [1:0] rnd_tbl [32];

  always #5 CK = ~CK;

  c17_bist #(.PATTERNS(NP), .SEED(SEED), .GOLDEN(GOLDEN)) dut (
    .CK(CK), .RST(RST), .start(start), .busy(busy), .done(done),
    .pass(pass), .signature(signature),
    .N1(N1), .N2(N2), .N3(N3), .N6(N6), .N7(N7), .N22(N22), .N23(N23)
  );

  // Core response {N23,N22}: 0 tied zero, 1 good c17, 2 n10 stuck-at-0, 3 random table.
  function automatic logic [1:0] core(input logic [4:0] p, input int m);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = p;
    if (m == 0) return 2'b00;
    if (m == 3) return rnd_tbl[p];
    n10 = (m == 2) ? 1'b0 : ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  assign {N23, N22} = core({N1, N2, N3, N6, N7}, mode);

  // Pattern k of a run.
  function automatic logic [4:0] pat_at(input int k);
    int p;
`ifdef C17_BIST_EXHAUSTIVE_EN
    p = k % 32;
`else
    p = int'(SEED);
    for (int i = 0; i < k; i++) p = ((p << 1) & 31) | (((p >> 4) ^ (p >> 2)) & 1);
`endif
    return 5'(p);
  endfunction

  // Polynomial-division step of the signature register.
  function automatic int misr_step(input int m, input int r);
    m = m << 1;
    if ((m & 256) != 0) m = m ^ 'h11D;
    return (m ^ r) & 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] sig, input logic ps);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " pass"}, 32'(pass), 32'(ps));
    chk({tag, " sig"}, 32'(signature), 32'(sig));
    chk({tag, " pat"}, 32'({N1, N2, N3, N6, N7}), 0);
  endtask

  task automatic start_run;
    start = 1'b1;
    tick;
  endtask

  // Checks one run from cycle t+1 through the cycle after done.
  task automatic run_body(input bit hold, input bit restart);
    int sig;
    logic [4:0] p;
    logic exp_pass;
    sig = 0;
    for (int k = 0; k < int'(NP); k++) begin
      p = pat_at(k);
      chk($sformatf("run m%0d k%0d busy", mode, k), 32'(busy), 1);
      chk($sformatf("run m%0d k%0d done", mode, k), 32'(done), 0);
      chk($sformatf("run m%0d k%0d pat", mode, k), 32'({N1, N2, N3, N6, N7}), 32'(p));
      chk($sformatf("run m%0d k%0d sig", mode, k), 32'(signature), 32'(sig));
      sig = misr_step(sig, int'(core(p, mode)));
      start = hold;
      tick;
    end
    exp_pass = (8'(sig) == GOLDEN);
    chk($sformatf("done m%0d done", mode), 32'(done), 1);
    chk($sformatf("done m%0d busy", mode), 32'(busy), 0);
    chk($sformatf("done m%0d sig", mode), 32'(signature), 32'(sig));
    chk($sformatf("done m%0d pass", mode), 32'(pass), 32'(exp_pass));
    chk($sformatf("done m%0d pat", mode), 32'({N1, N2, N3, N6, N7}), 0);
    start = restart;
    tick;
    if (restart) begin
      chk("restart busy", 32'(busy), 1);
      chk("restart done", 32'(done), 0);
      chk("restart pass", 32'(pass), 0);
      chk("restart sig", 32'(signature), 0);
      chk("restart pat", 32'({N1, N2, N3, N6, N7}), 32'(pat_at(0)));
    end else begin
      chk_idle($sformatf("post m%0d", mode), 8'(sig), exp_pass);
    end
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) rnd_tbl[i] = 2'($urandom);
    tick;
    tick;
    chk_idle("reset", 8'h00, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_idle($sformatf("idle%0d", i), 8'h00, 1'b0);
    end

    // Tied-zero, good core, faulty core, random responses with start held.
    mode = 0; start_run; run_body(1'b0, 1'b0);
    mode = 1; start_run; run_body(1'b0, 1'b0);
    mode = 2; start_run; run_body(1'b0, 1'b0);
    mode = 3; start_run; run_body(1'b1, 1'b0);

    // Restart from the DONE cycle.
    mode = 1; start_run; run_body(1'b0, 1'b1);
    run_body(1'b0, 1'b0);

    // Reset mid-run at cycle t+3: partial signature discarded, no done pulse.
    mode = 3;
    start_run;
    start = 1'b0;
    tick;
    tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk_idle("midrst", 8'h00, 1'b0);
    for (int i = 0; i < int'(NP) + 3; i++) begin
      tick;
      chk($sformatf("midrst idle%0d done", i), 32'(done), 0);
      chk($sformatf("midrst idle%0d busy", i), 32'(busy), 0);
    end

    // Recovery run after reset.
    mode = 2; start_run; run_body(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
